// File: rtl/pixel_2ppc_to_1ppc.sv
`default_nettype none
// ============================================================================
// pixel_2ppc_to_1ppc : non-stallable 2PPC pair FIFO feeding a 1PPC valid/ready
//                      serializer with frame coordinate and marker regeneration
// Rev 1.0
// ============================================================================
module pixel_2ppc_to_1ppc #(
    parameter int P_DEPTH          = 8,
    parameter int OUT_FRAME_WIDTH  = 540,
    parameter int OUT_FRAME_HEIGHT = 360,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          soft_clr,
    input  logic [2*P_DEPTH-1:0]          in_red,
    input  logic [2*P_DEPTH-1:0]          in_green,
    input  logic [2*P_DEPTH-1:0]          in_blue,
    input  logic                          in_valid,
    output logic [P_DEPTH-1:0]            out_red,
    output logic [P_DEPTH-1:0]            out_green,
    output logic [P_DEPTH-1:0]            out_blue,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [10:0]                   out_x,
    output logic [10:0]                   out_y,
    output logic                          out_sol,
    output logic                          out_eol,
    output logic                          out_sof,
    output logic                          out_eof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 6 * P_DEPTH;
    localparam int XW = 3 * P_DEPTH;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [10:0] c_XMAX  = 11'(OUT_FRAME_WIDTH - 1);
    localparam logic [10:0] c_YMAX  = 11'(OUT_FRAME_HEIGHT - 1);

    // LOAD is the one-cycle stage between popping into hold_q and presenting it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_LOW  = 2'd2,
        S_HIGH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [PW-1:0]       hold_q, hold_d;
    logic [XW-1:0]       pix_q, pix_d;
    logic                valid_q, valid_d;
    logic [10:0]         x_q, x_d;
    logic [10:0]         y_q, y_d;
    logic [3:0]          mark_q, mark_d;
    logic                ovf_q, ovf_d;

    logic                w_hs;
    logic                w_push;
    logic                w_pop;
    logic                w_load;
    logic                w_hi;
    logic [PW-1:0]       w_src;
    logic [PW-1:0]       w_in_pair;
    logic [PW-1:0]       w_rd_pair;

    // Pair layout: red in [2P-1:0], green in [4P-1:2P], blue in [6P-1:4P]
    function automatic logic [XW-1:0] sel_pix(input logic [PW-1:0] pair, input logic hi);
        logic [2*P_DEPTH-1:0] r;
        logic [2*P_DEPTH-1:0] g;
        logic [2*P_DEPTH-1:0] b;
        r = pair[2*P_DEPTH-1:0];
        g = pair[4*P_DEPTH-1:2*P_DEPTH];
        b = pair[6*P_DEPTH-1:4*P_DEPTH];
        if (hi) begin
            return {b[2*P_DEPTH-1:P_DEPTH], g[2*P_DEPTH-1:P_DEPTH], r[2*P_DEPTH-1:P_DEPTH]};
        end
        return {b[P_DEPTH-1:0], g[P_DEPTH-1:0], r[P_DEPTH-1:0]};
    endfunction

    assign w_in_pair = {in_blue, in_green, in_red};
    assign w_rd_pair = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        pix_d    = pix_q;
        valid_d  = valid_q;
        x_d      = x_q;
        y_d      = y_q;
        mark_d   = mark_q;
        ovf_d    = ovf_q;
        w_hs     = valid_q & out_ready;
        w_pop    = 1'b0;
        w_push   = 1'b0;
        w_load   = 1'b0;
        w_hi     = 1'b0;
        w_src    = hold_q;

        if (soft_clr) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pix_d    = '0;
            valid_d  = 1'b0;
            x_d      = '0;
            y_d      = '0;
            mark_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (w_hs) begin
                if (x_q == c_XMAX) begin
                    x_d = '0;
                    y_d = (y_q == c_YMAX) ? 11'd0 : y_q + 11'd1;
                end else begin
                    x_d = x_q + 11'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        w_pop   = 1'b1;
                        hold_d  = w_rd_pair;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_load  = 1'b1;
                    state_d = S_LOW;
                end
                S_LOW: begin
                    if (w_hs) begin
                        w_load  = 1'b1;
                        w_hi    = 1'b1;
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_hs) begin
                        // Chain straight from the FIFO so back-to-back pairs carry no bubble
                        if (count_q != '0) begin
                            w_pop   = 1'b1;
                            hold_d  = w_rd_pair;
                            w_src   = w_rd_pair;
                            w_load  = 1'b1;
                            state_d = S_LOW;
                        end else begin
                            valid_d = 1'b0;
                            mark_d  = '0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            w_push = in_valid & ((count_q != c_DEPTH) | w_pop);
            if (in_valid & ~w_push) begin
                ovf_d = 1'b1;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (w_push & ~w_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (~w_push & w_pop) begin
                count_d = count_q - (AW+1)'(1);
            end

            if (w_load) begin
                pix_d   = sel_pix(w_src, w_hi);
                valid_d = 1'b1;
                mark_d  = {x_d == 11'd0,
                           x_d == c_XMAX,
                           (x_d == 11'd0) & (y_d == 11'd0),
                           (x_d == c_XMAX) & (y_d == c_YMAX)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_in_pair;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            pix_q    <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            mark_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            pix_q    <= pix_d;
            valid_q  <= valid_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mark_q   <= mark_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_red    = pix_q[P_DEPTH-1:0];
    assign out_green  = pix_q[2*P_DEPTH-1:P_DEPTH];
    assign out_blue   = pix_q[3*P_DEPTH-1:2*P_DEPTH];
    assign out_valid  = valid_q;
    assign out_x      = x_q;
    assign out_y      = y_q;
    assign out_sol    = mark_q[3];
    assign out_eol    = mark_q[2];
    assign out_sof    = mark_q[1];
    assign out_eof    = mark_q[0];
    assign fifo_level = count_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_2ppc_to_1ppc.sv
`default_nettype none
// ============================================================================
// tb_pixel_2ppc_to_1ppc : directed bench for the 2PPC-to-1PPC gearbox
// Rev 1.0
// ============================================================================
module tb_pixel_2ppc_to_1ppc;
    localparam int P = 8;
    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_clr = 1'b0;
    logic [15:0] in_red = '0, in_green = '0, in_blue = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_red, out_green, out_blue;
    logic        out_valid;
    logic [10:0] out_x, out_y;
    logic        out_sol, out_eol, out_sof, out_eof;
    logic [2:0]  fifo_level;
    logic        overflow;

    pixel_2ppc_to_1ppc #(
        .P_DEPTH(P), .OUT_FRAME_WIDTH(W), .OUT_FRAME_HEIGHT(H), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y),
        .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef logic [49:0] pix_t;
    pix_t recq[$];
    int   cycq[$];
    bit   rec_en = 1'b0;

    typedef struct {
        logic        iv;
        logic [15:0] r, g, b;
        logic        rdy;
        logic        ev;
        logic [7:0]  er, eg, eb;
        logic [10:0] ex, ey;
        logic [3:0]  emk;
        logic [2:0]  elvl;
    } vec_t;
    vec_t tbl[6];

    function automatic pix_t got_pix();
        return {out_red, out_green, out_blue, out_x, out_y, out_sol, out_eol, out_sof, out_eof};
    endfunction

    // Pixel p of a stream restarted by soft_clr: data encodes p, coords wrap on 8x2
    function automatic pix_t exp_pix(int p);
        int q;
        logic [10:0] x, y;
        q = p % (W * H);
        x = 11'(q % W);
        y = 11'(q / W);
        return {8'(p), 8'(p + 64), 8'(p + 128), x, y,
                x == 11'd0, x == 11'(W - 1), q == 0, q == W * H - 1};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_pair(input int k);
        in_red   = {8'(2*k + 1),       8'(2*k)};
        in_green = {8'(2*k + 1 + 64),  8'(2*k + 64)};
        in_blue  = {8'(2*k + 1 + 128), 8'(2*k + 128)};
    endtask

    task automatic tick();
        if (rec_en && out_valid && out_ready) begin
            recq.push_back(got_pix());
            cycq.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear();
        soft_clr = 1'b1;
        in_valid = 1'b0;
        tick();
        soft_clr = 1'b0;
        recq.delete();
        cycq.delete();
    endtask

    task automatic check_stream(input string name, input int n);
        check({name, "_count"}, 64'(recq.size()), 64'(n));
        for (int i = 0; i < recq.size() && i < n; i++) begin
            check($sformatf("%s_pix%0d", name, i), 64'(recq[i]), 64'(exp_pix(i)));
        end
    endtask

    task automatic push_pairs(input int n);
        for (int k = 0; k < n; k++) begin
            set_pair(k);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_t snap;
        int   maxlvl, hold_err;
        bit   have_snap;

        // Single pair through an idle gearbox, one row per clock edge
        tbl[0] = '{1'b1, 16'hB2A1, 16'hD4C3, 16'hF6E5, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 11'd0, 11'd0, 4'b0000, 3'd1};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 11'd0, 11'd0, 4'b0000, 3'd0};
        tbl[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'hA1, 8'hC3, 8'hE5, 11'd0, 11'd0, 4'b1010, 3'd0};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'hB2, 8'hD4, 8'hF6, 11'd1, 11'd0, 4'b0000, 3'd0};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 11'd0, 11'd0, 4'b0000, 3'd0};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 11'd0, 11'd0, 4'b0000, 3'd0};

        repeat (2) @(negedge clk);
        check("reset_state", 64'({out_valid, got_pix(), fifo_level, overflow}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            in_valid  = tbl[i].iv;
            in_red    = tbl[i].r;
            in_green  = tbl[i].g;
            in_blue   = tbl[i].b;
            out_ready = tbl[i].rdy;
            tick();
            if (tbl[i].ev) begin
                check($sformatf("single_row%0d", i),
                      64'({out_valid, got_pix(), fifo_level}),
                      64'({1'b1, tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].ex, tbl[i].ey, tbl[i].emk, tbl[i].elvl}));
            end else begin
                check($sformatf("single_row%0d", i), 64'({out_valid, fifo_level}), 64'({1'b0, tbl[i].elvl}));
            end
        end

        // Full 8x2 frame plus the first pair of the next frame
        clear();
        rec_en = 1'b1;
        out_ready = 1'b1;
        push_pairs(8);
        repeat (8) tick();
        set_pair(8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check_stream("frame", 18);

        // Backpressure: 4 pairs arrive during a 10-cycle stall
        clear();
        out_ready = 1'b0;
        maxlvl = 0;
        hold_err = 0;
        have_snap = 1'b0;
        snap = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0) && (c < 8);
            if (in_valid) set_pair(c / 2);
            tick();
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (out_valid) begin
                if (!have_snap) begin
                    snap = got_pix();
                    have_snap = 1'b1;
                end else if (got_pix() !== snap) begin
                    hold_err++;
                end
            end
        end
        in_valid = 1'b0;
        check("bp_level_peak", 64'(maxlvl), 64'(3));
        check("bp_stall_pixel", 64'(snap), 64'(exp_pix(0)));
        check("bp_hold_changes", 64'(hold_err), 64'(0));
        out_ready = 1'b1;
        repeat (12) tick();
        check_stream("bp", 8);
        if (cycq.size() == 8) check("bp_back_to_back", 64'(cycq[7] - cycq[0]), 64'(7));
        else check("bp_back_to_back", 64'(cycq.size()), 64'(8));
        check("bp_overflow", 64'(overflow), 64'(0));

        // Overflow: 6 pairs against 4 FIFO entries plus the serializer pair
        clear();
        out_ready = 1'b0;
        push_pairs(6);
        check("ovf_state", 64'({out_valid, fifo_level, overflow}), 64'({1'b1, 3'd4, 1'b1}));
        repeat (3) tick();
        check("ovf_sticky", 64'(overflow), 64'(1));
        out_ready = 1'b1;
        repeat (16) tick();
        check_stream("ovf", 10);
        check("ovf_after_drain", 64'({overflow, fifo_level}), 64'({1'b1, 3'd0}));
        clear();
        check("ovf_softclr", 64'(overflow), 64'(0));

        // Full FIFO: push lands on the HIGH-pixel handshake
        out_ready = 1'b0;
        push_pairs(5);
        check("fpp_full", 64'(fifo_level), 64'(4));
        out_ready = 1'b1;
        tick();
        set_pair(5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fpp_level_ovf", 64'({fifo_level, overflow}), 64'({3'd4, 1'b0}));
        repeat (16) tick();
        check_stream("fpp", 12);

        // soft_clr mid-line with 3 pairs queued
        clear();
        rec_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_pair(k);
            in_valid = 1'b1;
            out_ready = !(out_valid && out_x == 11'd5);
            tick();
            in_valid = 1'b0;
            out_ready = !(out_valid && out_x == 11'd5);
            tick();
        end
        check("sclr_pre", 64'({out_valid, out_x, fifo_level}), 64'({1'b1, 11'd5, 3'd3}));
        soft_clr = 1'b1;
        in_valid = 1'b1;
        in_red = 16'hEEEE;
        in_green = 16'hEEEE;
        in_blue = 16'hEEEE;
        tick();
        soft_clr = 1'b0;
        in_valid = 1'b0;
        check("sclr_post", 64'({out_valid, fifo_level, out_x, out_y, overflow}), 64'(0));
        recq.delete();
        cycq.delete();
        rec_en = 1'b1;
        out_ready = 1'b1;
        set_pair(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check_stream("sclr", 2);

        // Asynchronous reset while stalled
        clear();
        out_ready = 1'b0;
        push_pairs(2);
        check("arst_pre", 64'({out_valid, fifo_level}), 64'({1'b1, 3'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_immediate", 64'({out_valid, got_pix(), fifo_level, overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
